dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory of the single-cycle MIPS between two requesters.
  - Port 0: the core load/store path.
  - Port 1: a bench/debug loader.
- Each requester has a valid/ready request handshake and a one-cycle response pulse.
- Arbitrates round-robin, issues one registered memory access at a time, waits a fixed memory latency and returns read data to the winner.
- Sits between mips/top and dmem.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 1: cycles from mem_en to mem_rdata valid; legal range 1..15; elaboration error outside that range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_we  in  2  1 = write, 0 = read.
- req_addr  in  2xAW  byte address per requester.
- req_wdata  in  2xDW  write data per requester.
- rsp_valid  out  2  one-cycle response pulse to the granted requester.
- rsp_rdata  out  DW  read data, valid with rsp_valid; 0 for writes.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  word-aligned address (req_addr with [1:0] forced to 0).
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values (asynchronous, reset=0):
  - state=IDLE, last_grant=1 (port 0 wins first), cnt=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner selection:
    - One valid: that port wins.
    - Both valid: the port != last_grant wins.
  - req_ready[winner]=1 combinationally. Accept occurs on valid&ready.
  - On accept:
    - Register we/addr/wdata and grant index.
    - Set last_grant=winner.
    - Go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - mem_en=1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the latched values.
  - cnt<=MEM_LAT-1.
  - Go to WAIT.
- WAIT:
  - Decrement cnt.
  - When cnt==0, capture mem_rdata (or 0 if write) into rsp_rdata and go to RESP.
- RESP:
  - rsp_valid[grant]=1 for one cycle; go to IDLE.
  - req_ready stays 0 in every state other than IDLE.
- Latency:
  - Accept at cycle N, mem_en at N+1, rsp_valid at N+2+MEM_LAT.
  - Peak throughput: one transaction per MEM_LAT+3 cycles.
- Handshake rules:
  - A requester holds valid/we/addr/wdata stable until accepted.
  - Deasserting valid before accept is legal; that request is dropped, with no side effects.
  - Responses have no backpressure.
  - A requester may present a new request in the same cycle as its rsp_valid; it is considered on the next IDLE cycle.
- Boundary conditions:
  - Both ports valid continuously: grants alternate 0,1,0,1.
  - Only one port valid: it is granted repeatedly regardless of last_grant.
  - Reset mid-transaction: in-flight access is abandoned, no rsp_valid, and mem_en is forced 0 immediately.
  - Misaligned req_addr: low 2 bits are ignored, with no error.
  - mem_rdata is sampled only in the final WAIT cycle; other values are don't-care.

Optional Feature:
- Macro DMEM_ARB_PRIO_EN.
- Defined: fixed priority replaces round-robin. Port 0 always wins when valid, so port 1 may starve. last_grant is still updated but unused.
- Undefined: round-robin exactly as described in Behaviour.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - localparam NREQ=2;
  - a function rr_pick(valid, last_grant) returning the winner index.
- Natural sub-module: dmem_arb_picker, the combinational winner select. It contains the DMEM_ARB_PRIO_EN switch, so the FSM in dmem_arbiter is identical in both builds.

Test Plan:
1. Reset low 22 ns, then port 0 writes addr 84 data 7 with MEM_LAT=1 -> mem_en one cycle with mem_we=1, mem_addr=84, mem_wdata=7; rsp_valid[0] at accept+3, rsp_rdata=0.
2. Port 1 reads addr 84, memory model returns 7 -> rsp_valid[1] pulse with rsp_rdata=7 and rsp_valid[0]=0; with MEM_LAT=4, rsp arrives at accept+6.
3. Both ports valid continuously for 6 transactions, round-robin build -> grant order 0,1,0,1,0,1; req_ready is never 2'b11.
4. Same stimulus with DMEM_ARB_PRIO_EN defined -> all 6 grants to port 0; port 1 is granted on the first IDLE after port 0 drops valid.
5. Assert reset in the WAIT state of a read -> mem_en=0, no rsp_valid and state=IDLE immediately; the next request after release completes normally.
6. Port 0 requests addr 0x57 (misaligned) -> mem_addr=0x54; port 1 deasserts valid while port 0 is busy -> no access for port 1 and no rsp_valid[1].

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Winner selection helper used by the round-robin picker build.
package dmem_arb_pkg;

    localparam int NREQ  = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // With both requesters valid, the one not served last time wins.
    function automatic logic rr_pick(input logic [NREQ-1:0] valid, input logic last_grant);
        logic w;
        if (valid == 2'b11) begin
            w = ~last_grant;
        end else begin
            w = valid[1];
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational winner select for the data-memory arbiter.
// DMEM_ARB_PRIO_EN selects fixed priority (port 0 first) instead of round-robin.
module dmem_arb_picker
    import dmem_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_last_grant,
    output logic            o_winner,
    output logic            o_any
);

    assign o_any = |i_valid;

`ifdef DMEM_ARB_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
    assign o_winner            = ~i_valid[0];
`else
    assign o_winner = rr_pick(i_valid, i_last_grant);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one access in flight,
// fixed MEM_LAT read latency. Build option DMEM_ARB_PRIO_EN lives in dmem_arb_picker.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("dmem_arbiter: MEM_LAT must be within 1..15");
    end

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_last_grant;
    logic             r_grant;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_rsp_rdata;
    logic             w_winner;
    logic             w_any;
    logic             w_accept;
    logic             w_unused_addr_lsb;

    // Byte offset is dropped on purpose; the memory is word addressed.
    assign w_unused_addr_lsb = ^{req_addr[0][1:0], req_addr[1][1:0]};

    dmem_arb_picker u_picker (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (r_cnt == '0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ready is also held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mem_en    = 1'b0;
        case (r_state)
            IDLE:    if (w_any && reset) req_ready[w_winner] = 1'b1;
            ISSUE:   mem_en = 1'b1;
            RESP:    rsp_valid[r_grant] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_we         <= req_we[w_winner];
                r_addr       <= {req_addr[w_winner][AW-1:2], 2'b00};
                r_wdata      <= req_wdata[w_winner];
            end
            if (r_state == ISSUE) begin
                r_cnt <= CNT_W'(MEM_LAT - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == WAIT && r_cnt == '0) begin
                r_rsp_rdata <= r_we ? '0 : mem_rdata;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_rdata = r_rsp_rdata;

endmodule
